fx2_slave_fifo_ctrl: RTL and testbench

//  FPGA-side master of the FX2 slave-FIFO bus; consumes the command/data stream
//  the FX2 produces and returns read data and acks on the IN endpoint.

---
 rtl/fx2_slave_fifo_ctrl.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_fx2_slave_fifo_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_slave_fifo_ctrl.sv
// FPGA-side master of the FX2 slave-FIFO bus: parses the 8-word command header,
// moves words between the FX2 FIFOs and the terminal bus, returns acks. Option: FX2_READ_CHECKSUM_EN.
module fx2_slave_fifo_ctrl #(
    parameter logic [1:0]  EP_OUT_ADDR = 2'd0,
    parameter logic [1:0]  EP_IN_ADDR  = 2'd2,
    parameter logic [7:0]  MAGIC       = 8'hC3,
    parameter logic [15:0] ACK_WORD    = 16'hAA55
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic [15:0] fd_in,
    output logic [15:0] fd_out,
    output logic        fd_oe,
    input  logic        empty_b,
    input  logic        full_b,
    input  logic        cmd_b,
    output logic        slrd_b,
    output logic        slwr_b,
    output logic        sloe_b,
    output logic [1:0]  fifoaddr,
    output logic        pktend_b,
    output logic [15:0] di_term_addr,
    output logic [31:0] di_reg_addr,
    output logic [31:0] di_len,
    output logic        di_read_mode,
    output logic        di_write_mode,
    output logic        di_read_req,
    input  logic        di_read_rdy,
    input  logic        di_read_valid,
    input  logic [15:0] di_reg_datao,
    output logic        di_write,
    input  logic        di_write_rdy,
    output logic [15:0] di_reg_datai,
    output logic [3:0]  status
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_OE_SETUP  = 4'd1,
        S_HDR       = 4'd2,
        S_CMD_DEC   = 4'd3,
        S_RD_DATA   = 4'd4,
        S_WR_DATA   = 4'd5,
        S_ACK       = 4'd6,
        S_PKTEND    = 4'd7,
        S_WAIT_FLAG = 4'd8,
        S_ERR       = 4'd9
    } state_t;

    state_t      state_q;
    logic [2:0]  hdr_idx_q;
    logic [7:0]  magic_q;
    logic [7:0]  cmd_q;
    logic [15:0] w7_q;
    logic [15:0] term_q;
    logic [31:0] reg_q;
    logic [31:0] len_q;
    logic [31:0] words_q;
    logic [31:0] cnt_q;
    logic [31:0] req_cnt_q;
    logic [1:0]  out_q;
    logic [1:0]  bcnt_q;
    logic        wptr_q;
    logic        rptr_q;
    logic [15:0] buf_q [2];
    logic [1:0]  ack_idx_q;
    logic        is_rd_q;
    logic        fd_oe_q;
    logic        sloe_b_q;
    logic [1:0]  fifoaddr_q;
    logic        pktend_b_q;
    logic        rd_mode_q;
    logic        wr_mode_q;
    logic        di_write_q;
    logic [15:0] datai_q;

    logic [31:0] words_w;
    logic        hdr_rd, wr_rd, err_rd;
    logic        rd_issue, rd_push, rd_pop, ack_wr;
    logic [1:0]  ack_last;
    logic [15:0] ack_word;
    logic [15:0] csum_w;

    // (len + 1) >> 1 written so it cannot overflow at len = 32'hFFFFFFFF
    assign words_w = {1'b0, len_q[31:1]} + {31'd0, len_q[0]};

    // Strobes are registered intent qualified by the live FX2 flags, so a FIFO is
    // never touched in a cycle where its flag forbids it.
    assign hdr_rd = (state_q == S_HDR) && empty_b;
    assign wr_rd  = (state_q == S_WR_DATA) && empty_b && di_write_rdy && (cnt_q != words_q);
    assign err_rd = (state_q == S_ERR) && empty_b;

    // Terminal handshake: di_read_req is accepted in any cycle di_read_rdy is high;
    // each accepted request returns exactly one di_read_valid beat later.
    // out_q counts requests whose word has not yet left the skid buffer, which
    // bounds buffer occupancy to its two entries.
    assign rd_issue = (state_q == S_RD_DATA) && di_read_rdy && (req_cnt_q != words_q) && (out_q < 2'd2);
    assign rd_push  = (state_q == S_RD_DATA) && di_read_valid;
    assign rd_pop   = (state_q == S_RD_DATA) && (bcnt_q != 2'd0) && full_b;
    assign ack_wr   = (state_q == S_ACK) && full_b;
    assign ack_last = is_rd_q ? 2'd1 : 2'd3;

`ifdef FX2_READ_CHECKSUM_EN
    logic [15:0] csum_q;
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            csum_q <= 16'h0000;
        end else if (state_q == S_CMD_DEC) begin
            csum_q <= 16'h0000;
        end else if (rd_pop) begin
            csum_q <= csum_q + buf_q[rptr_q];
        end
    end
    assign csum_w = csum_q;
`else
    assign csum_w = 16'h0000;
`endif

    always_comb begin
        ack_word = 16'h0000;
        if (is_rd_q) begin
            if (ack_idx_q == 2'd0) ack_word = csum_w;
        end else begin
            case (ack_idx_q)
                2'd0:    ack_word = ACK_WORD;
                2'd2:    ack_word = cnt_q[15:0];
                2'd3:    ack_word = cnt_q[31:16];
                default: ack_word = 16'h0000;
            endcase
        end
    end

    always_comb begin
        fd_out = 16'h0000;
        if (state_q == S_RD_DATA)  fd_out = buf_q[rptr_q];
        else if (state_q == S_ACK) fd_out = ack_word;
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            hdr_idx_q  <= 3'd0;
            magic_q    <= 8'h00;
            cmd_q      <= 8'h00;
            w7_q       <= 16'h0000;
            term_q     <= 16'h0000;
            reg_q      <= 32'h0;
            len_q      <= 32'h0;
            words_q    <= 32'h0;
            cnt_q      <= 32'h0;
            req_cnt_q  <= 32'h0;
            out_q      <= 2'd0;
            bcnt_q     <= 2'd0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            buf_q[0]   <= 16'h0000;
            buf_q[1]   <= 16'h0000;
            ack_idx_q  <= 2'd0;
            is_rd_q    <= 1'b0;
            fd_oe_q    <= 1'b0;
            sloe_b_q   <= 1'b1;
            fifoaddr_q <= EP_OUT_ADDR;
            pktend_b_q <= 1'b1;
            rd_mode_q  <= 1'b0;
            wr_mode_q  <= 1'b0;
            di_write_q <= 1'b0;
            datai_q    <= 16'h0000;
        end else begin
            di_write_q <= 1'b0;
            if (rd_issue) req_cnt_q <= req_cnt_q + 32'd1;
            if (rd_push) begin
                buf_q[wptr_q] <= di_reg_datao;
                wptr_q        <= ~wptr_q;
            end
            if (rd_pop) begin
                rptr_q <= ~rptr_q;
                cnt_q  <= cnt_q + 32'd1;
            end
            bcnt_q <= bcnt_q + {1'b0, rd_push} - {1'b0, rd_pop};
            out_q  <= out_q + {1'b0, rd_issue} - {1'b0, rd_pop};

            case (state_q)
                S_IDLE: begin
                    if (!cmd_b) begin
                        state_q    <= S_OE_SETUP;
                        fifoaddr_q <= EP_OUT_ADDR;
                        sloe_b_q   <= 1'b0;
                        hdr_idx_q  <= 3'd0;
                    end
                end
                S_OE_SETUP: state_q <= S_HDR;
                S_HDR: begin
                    if (hdr_rd) begin
                        case (hdr_idx_q)
                            3'd0: begin magic_q <= fd_in[15:8]; cmd_q <= fd_in[7:0]; end
                            3'd1: term_q        <= fd_in;
                            3'd2: reg_q[15:0]   <= fd_in;
                            3'd3: reg_q[31:16]  <= fd_in;
                            3'd4: len_q[15:0]   <= fd_in;
                            3'd5: len_q[31:16]  <= fd_in;
                            3'd7: w7_q          <= fd_in;
                            default: ;
                        endcase
                        hdr_idx_q <= hdr_idx_q + 3'd1;
                        if (hdr_idx_q == 3'd7) state_q <= S_CMD_DEC;
                    end
                end
                S_CMD_DEC: begin
                    words_q   <= words_w;
                    cnt_q     <= 32'h0;
                    req_cnt_q <= 32'h0;
                    out_q     <= 2'd0;
                    bcnt_q    <= 2'd0;
                    wptr_q    <= 1'b0;
                    rptr_q    <= 1'b0;
                    ack_idx_q <= 2'd0;
                    is_rd_q   <= (cmd_q == 8'd1);
                    if (magic_q != MAGIC || w7_q != ACK_WORD || (cmd_q != 8'd1 && cmd_q != 8'd2)) begin
                        state_q <= S_ERR;
                    end else if (words_w == 32'h0) begin
                        state_q    <= S_ACK;
                        sloe_b_q   <= 1'b1;
                        fifoaddr_q <= EP_IN_ADDR;
                        fd_oe_q    <= 1'b1;
                    end else if (cmd_q == 8'd1) begin
                        state_q    <= S_RD_DATA;
                        sloe_b_q   <= 1'b1;
                        fifoaddr_q <= EP_IN_ADDR;
                        fd_oe_q    <= 1'b1;
                        rd_mode_q  <= 1'b1;
                    end else begin
                        state_q   <= S_WR_DATA;
                        wr_mode_q <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (cnt_q == words_q) begin
                        state_q   <= S_ACK;
                        rd_mode_q <= 1'b0;
                    end
                end
                S_WR_DATA: begin
                    if (wr_rd) begin
                        di_write_q <= 1'b1;
                        datai_q    <= fd_in;
                        cnt_q      <= cnt_q + 32'd1;
                    end else if (cnt_q == words_q) begin
                        // reached only after the last di_write pulse has been issued
                        state_q    <= S_ACK;
                        wr_mode_q  <= 1'b0;
                        sloe_b_q   <= 1'b1;
                        fifoaddr_q <= EP_IN_ADDR;
                        fd_oe_q    <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (ack_wr) begin
                        ack_idx_q <= ack_idx_q + 2'd1;
                        if (ack_idx_q == ack_last) begin
                            state_q    <= S_PKTEND;
                            pktend_b_q <= 1'b0;
                        end
                    end
                end
                S_PKTEND: begin
                    state_q    <= S_WAIT_FLAG;
                    pktend_b_q <= 1'b1;
                    fd_oe_q    <= 1'b0;
                    fifoaddr_q <= EP_OUT_ADDR;
                end
                S_WAIT_FLAG: if (cmd_b) state_q <= S_IDLE;
                S_ERR: begin
                    if (cmd_b) begin
                        state_q  <= S_IDLE;
                        sloe_b_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign slrd_b        = ~(hdr_rd | wr_rd | err_rd);
    assign slwr_b        = ~(rd_pop | ack_wr);
    assign fd_oe         = fd_oe_q;
    assign sloe_b        = sloe_b_q;
    assign fifoaddr      = fifoaddr_q;
    assign pktend_b      = pktend_b_q;
    assign di_term_addr  = term_q;
    assign di_reg_addr   = reg_q;
    assign di_len        = len_q;
    assign di_read_mode  = rd_mode_q;
    assign di_write_mode = wr_mode_q;
    assign di_read_req   = rd_issue;
    assign di_write      = di_write_q;
    assign di_reg_datai  = datai_q;
    assign status        = state_q;

endmodule

// File: tb/tb_fx2_slave_fifo_ctrl.sv
// Directed bench for fx2_slave_fifo_ctrl: an FX2 FIFO model and a terminal model
// around the DUT, with hand-derived expected IN-endpoint words in exp_q.
module tb_fx2_slave_fifo_ctrl;

    logic        ifclk = 1'b0;
    logic        resetb;
    logic [15:0] fd_in;
    logic [15:0] fd_out;
    logic        fd_oe;
    logic        empty_b;
    logic        full_b;
    logic        cmd_b;
    logic        slrd_b, slwr_b, sloe_b, pktend_b;
    logic [1:0]  fifoaddr;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_read_mode, di_write_mode, di_read_req, di_read_rdy, di_read_valid;
    logic [15:0] di_reg_datao;
    logic        di_write, di_write_rdy;
    logic [15:0] di_reg_datai;
    logic [3:0]  status;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] host_q[$];
    logic [15:0] in_q[$];
    logic [15:0] wr_q[$];
    logic [15:0] pend_q[$];
    logic [15:0] exp_q[$];
    int pkt_cnt = 0;
    int req_cnt = 0;
    int rd_idx  = 0;
    int both_low = 0, rd_empty = 0, wr_full = 0, bad_addr = 0;

    fx2_slave_fifo_ctrl dut (
        .ifclk(ifclk), .resetb(resetb), .fd_in(fd_in), .fd_out(fd_out), .fd_oe(fd_oe),
        .empty_b(empty_b), .full_b(full_b), .cmd_b(cmd_b), .slrd_b(slrd_b), .slwr_b(slwr_b),
        .sloe_b(sloe_b), .fifoaddr(fifoaddr), .pktend_b(pktend_b), .di_term_addr(di_term_addr),
        .di_reg_addr(di_reg_addr), .di_len(di_len), .di_read_mode(di_read_mode),
        .di_write_mode(di_write_mode), .di_read_req(di_read_req), .di_read_rdy(di_read_rdy),
        .di_read_valid(di_read_valid), .di_reg_datao(di_reg_datao), .di_write(di_write),
        .di_write_rdy(di_write_rdy), .di_reg_datai(di_reg_datai), .status(status)
    );

    // clock / reset
    always #5 ifclk = ~ifclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] term_data(input int k);
        logic [15:0] kk;
        kk = 16'(k);
        return kk * 16'h1357 + 16'h2468;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FX2 FIFOs + terminal: strobes sampled 1 ns before the edge, effects applied 1 ns after
    initial begin
        logic s_rd, s_wr, s_pe, s_dw, s_req, s_emp, s_full, s_oe, s_sloe;
        logic [1:0]  s_addr;
        logic [15:0] s_out, s_dat;
        fd_in = 16'h0; empty_b = 1'b0; di_read_valid = 1'b0; di_reg_datao = 16'h0;
        forever begin
            @(negedge ifclk); #4;
            s_rd = slrd_b; s_wr = slwr_b; s_pe = pktend_b; s_dw = di_write; s_req = di_read_req;
            s_emp = empty_b; s_full = full_b; s_oe = fd_oe; s_sloe = sloe_b; s_addr = fifoaddr;
            s_out = fd_out; s_dat = di_reg_datai;
            @(posedge ifclk); #1;
            if (!resetb) begin
                pend_q.delete();
                di_read_valid = 1'b0;
            end else begin
                if (!s_rd && !s_wr) both_low++;
                if (!s_rd && !s_emp) rd_empty++;
                if (!s_wr && !s_full) wr_full++;
                if (!s_wr && (s_addr != 2'd2 || !s_oe)) bad_addr++;
                if (!s_rd && (s_addr != 2'd0 || s_sloe)) bad_addr++;
                if (!s_rd && host_q.size() > 0) void'(host_q.pop_front());
                if (!s_wr) in_q.push_back(s_out);
                if (!s_pe) pkt_cnt++;
                if (s_dw) wr_q.push_back(s_dat);
                if (s_req) begin
                    pend_q.push_back(term_data(rd_idx));
                    rd_idx++;
                    req_cnt++;
                end
                if (pend_q.size() > 0) begin
                    di_read_valid = 1'b1;
                    di_reg_datao  = pend_q.pop_front();
                end else begin
                    di_read_valid = 1'b0;
                end
            end
            empty_b = (host_q.size() != 0);
            fd_in   = empty_b ? host_q[0] : 16'h0;
        end
    end

    // driver tasks
    task automatic send_hdr(input logic [15:0] w0, input logic [15:0] term, input logic [31:0] ra,
                            input logic [31:0] len, input logic [15:0] w7);
        host_q.push_back(w0);
        host_q.push_back(term);
        host_q.push_back(ra[15:0]);
        host_q.push_back(ra[31:16]);
        host_q.push_back(len[15:0]);
        host_q.push_back(len[31:16]);
        host_q.push_back(16'h0000);
        host_q.push_back(w7);
    endtask

    task automatic wait_pkt(input int target, input string tag);
        int n = 0;
        while (pkt_cnt < target && n < 3000) begin
            @(posedge ifclk);
            n++;
        end
        #2;
        check({tag, "_pktend"}, 64'(pkt_cnt), 64'(target));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (status != 4'd0 && n < 200) begin
            @(posedge ifclk);
            n++;
        end
        #2;
        check({tag, "_idle"}, 64'(status), 64'd0);
    endtask

    // scoreboard: compare IN-endpoint words from in_base against exp_q
    task automatic compare_in(input string tag, input int in_base);
        int n;
        n = exp_q.size();
        check({tag, "_in_count"}, 64'(in_q.size() - in_base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (in_base + i < in_q.size())
                check($sformatf("%s_in%0d", tag, i), 64'(in_q[in_base + i]), 64'(exp_q[i]));
            else
                check($sformatf("%s_in%0d", tag, i), 64'hDEAD_0000_0000, 64'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    task automatic do_write(input string tag, input logic [15:0] term, input logic [31:0] ra,
                            input logic [15:0] val);
        int in_base, wr_base, tgt;
        in_base = in_q.size(); wr_base = wr_q.size(); tgt = pkt_cnt + 1;
        @(posedge ifclk); #2;
        send_hdr(16'hC302, term, ra, 32'd2, 16'hAA55);
        host_q.push_back(val);
        cmd_b = 1'b0;
        wait_pkt(tgt, tag);
        check({tag, "_nwrite"}, 64'(wr_q.size() - wr_base), 64'd1);
        if (wr_q.size() > wr_base) check({tag, "_wdata"}, 64'(wr_q[wr_base]), 64'(val));
        check({tag, "_term"}, 64'(di_term_addr), 64'(term));
        check({tag, "_reg"}, 64'(di_reg_addr), 64'(ra));
        check({tag, "_len"}, 64'(di_len), 64'd2);
        exp_q = '{16'hAA55, 16'h0000, 16'h0001, 16'h0000};
        compare_in(tag, in_base);
        cmd_b = 1'b1;
        wait_idle(tag);
    endtask

    task automatic do_read(input string tag, input logic [31:0] len, input int nw, input int stall_at);
        int in_base, req_base, idx0, tgt, n;
        logic [15:0] sum, d;
        in_base = in_q.size(); req_base = req_cnt; idx0 = rd_idx; tgt = pkt_cnt + 1;
        @(posedge ifclk); #2;
        send_hdr(16'hC301, 16'h0002, 32'h0000_0040, len, 16'hAA55);
        cmd_b = 1'b0;
        if (stall_at > 0) begin
            n = 0;
            while (in_q.size() < in_base + stall_at && n < 3000) begin
                @(posedge ifclk);
                n++;
            end
            #2;
            full_b = 1'b0;
            repeat (20) @(posedge ifclk);
            #2;
            check({tag, "_stall_nowrite"}, 64'(in_q.size() - in_base), 64'(stall_at));
            full_b = 1'b1;
        end
        wait_pkt(tgt, tag);
        check({tag, "_nreq"}, 64'(req_cnt - req_base), 64'(nw));
        sum = 16'h0000;
        for (int i = 0; i < nw; i++) begin
            d = term_data(idx0 + i);
            exp_q.push_back(d);
            sum = sum + d;
        end
`ifdef FX2_READ_CHECKSUM_EN
        exp_q.push_back(sum);
`else
        exp_q.push_back(16'h0000);
`endif
        exp_q.push_back(16'h0000);
        compare_in(tag, in_base);
        cmd_b = 1'b1;
        wait_idle(tag);
    endtask

    task automatic do_bad_hdr(input string tag, input logic [15:0] w0, input logic [15:0] w7);
        int in_base, wr_base, req_base;
        in_base = in_q.size(); wr_base = wr_q.size(); req_base = req_cnt;
        @(posedge ifclk); #2;
        send_hdr(w0, 16'h0003, 32'h0000_0100, 32'd4, w7);
        host_q.push_back(16'h1111);
        host_q.push_back(16'h2222);
        cmd_b = 1'b0;
        repeat (40) @(posedge ifclk);
        #2;
        check({tag, "_state_err"}, 64'(status), 64'd9);
        check({tag, "_drained"}, 64'(host_q.size()), 64'd0);
        check({tag, "_no_in"}, 64'(in_q.size() - in_base), 64'd0);
        check({tag, "_no_write"}, 64'(wr_q.size() - wr_base), 64'd0);
        check({tag, "_no_req"}, 64'(req_cnt - req_base), 64'd0);
        cmd_b = 1'b1;
        wait_idle(tag);
    endtask

    // {fd_oe, slrd_b, slwr_b, sloe_b, pktend_b, fifoaddr, rd_mode, wr_mode, read_req, write}
    function automatic logic [10:0] ctl_bits();
        return {fd_oe, slrd_b, slwr_b, sloe_b, pktend_b, fifoaddr,
                di_read_mode, di_write_mode, di_read_req, di_write};
    endfunction

    initial begin
        int wr_base, n;
        resetb = 1'b0; cmd_b = 1'b1; full_b = 1'b1; di_read_rdy = 1'b1; di_write_rdy = 1'b1;
        #23;
        check("rst_ctl", 64'(ctl_bits()), 64'(11'b0_1111_00_0000));
        check("rst_fd_out", 64'(fd_out), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_di_addr", {di_term_addr, di_reg_addr[15:0], di_len[15:0]}, 48'd0);
        @(posedge ifclk); #2;
        resetb = 1'b1;
        repeat (3) @(posedge ifclk);

        do_write("set_beef", 16'h0001, 32'h0000_0010, 16'hBEEF);
        do_read("rd_len6", 32'd6, 3, 0);
        do_read("rd_len3", 32'd3, 2, 0);
        do_read("rd_len0", 32'd0, 0, 0);
        do_read("rd_stall64", 32'd128, 64, 10);
        do_bad_hdr("bad_magic", 16'hC201, 16'hAA55);
        do_bad_hdr("bad_w7", 16'hC302, 16'h1234);

        // reset in the middle of a 4-word write stalled on an empty OUT FIFO
        wr_base = wr_q.size();
        @(posedge ifclk); #2;
        send_hdr(16'hC302, 16'h0005, 32'h0000_0020, 32'd8, 16'hAA55);
        host_q.push_back(16'h1111);
        host_q.push_back(16'h2222);
        cmd_b = 1'b0;
        n = 0;
        while (wr_q.size() < wr_base + 2 && n < 200) begin
            @(posedge ifclk);
            n++;
        end
        repeat (3) @(posedge ifclk);
        #2;
        check("midwr_nwrite", 64'(wr_q.size() - wr_base), 64'd2);
        check("midwr_state", 64'(status), 64'd5);
        check("midwr_mode", 64'(di_write_mode), 64'd1);
        @(posedge ifclk); #3;
        resetb = 1'b0;
        cmd_b  = 1'b1;
        #1;
        check("midwr_rst_ctl", 64'(ctl_bits()), 64'(11'b0_1111_00_0000));
        check("midwr_rst_status", 64'(status), 64'd0);
        check("midwr_rst_len", 64'(di_len), 64'd0);
        repeat (2) @(posedge ifclk);
        #2;
        resetb = 1'b1;
        repeat (2) @(posedge ifclk);
        do_write("after_rst", 16'h0007, 32'h0001_0002, 16'h5A5A);

        check("slrd_slwr_both_low", 64'(both_low), 64'd0);
        check("read_while_empty", 64'(rd_empty), 64'd0);
        check("write_while_full", 64'(wr_full), 64'd0);
        check("strobe_addr_oe", 64'(bad_addr), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
